// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the four-source round-robin operand arbiter.
// Contents: FSM state type, 3-bit selector type and its "no owner" code,
// and small helpers that turn a 2-bit winner index into selector and one-hot forms.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Codes 3'b000..3'b011 pick sources A..D; every other code selects nothing.
  typedef logic [2:0] sel_t;

  localparam sel_t SEL_NONE = 3'b100;

  function automatic sel_t sel_of(input logic [1:0] w);
    return {1'b0, w};
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

endpackage

// File: rtl/rr_prio4.sv
// Combinational round-robin pick over four requesters.
// Ports: Req/mask (4-bit request and exclusion mask), Ptr (first index scanned);
// Any (some unmasked request present), Win (first unmasked requester at or after Ptr, mod 4).
module rr_prio4 (
  input  logic [3:0] Req,
  input  logic [1:0] Ptr,
  input  logic [3:0] mask,
  output logic       Any,
  output logic [1:0] Win
);

  logic [3:0] eff;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    eff   = Req & ~mask;
    Any   = |eff;
    Win   = Ptr;
    idx   = Ptr;
    found = 1'b0;
    // Scan Ptr, Ptr+1, ... with natural 2-bit wrap; the first hit wins.
    for (int i = 0; i < 4; i++) begin
      idx = Ptr + 2'(i);
      if (!found && eff[idx]) begin
        Win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_mux64.sv
// Four-requester round-robin arbiter feeding one WIDTH-bit word onto a valid/ready output stage.
// Ports: clk, reset (async active-low), Req[3:0], A..D source words, Ack[3:0] capture pulse,
// Seletor (owner code, 3'b100 when none), Saida/Valid/Ready output handshake.
// Optional: define ARB_BACK2BACK_EN to re-arbitrate on acceptance and load the next word without a bubble.
module arbiter_mux64
  import arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [3:0]       Ack,
  output sel_t             Seletor,
  output logic [WIDTH-1:0] Saida,
  output logic             Valid,
  input  logic             Ready
);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       own_q, own_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  sel_t             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [3:0]       ack_q, ack_d;

  logic [1:0]       arb_ptr;
  logic [3:0]       arb_mask;
  logic             arb_any;
  logic [1:0]       arb_win;
  logic [WIDTH-1:0] word_sel;
  logic             accept;

  // In IDLE the scan starts at the stored pointer. With back-to-back enabled, a BUSY
  // re-arbitration starts just past the owner and excludes it so it cannot win twice.
  always_comb begin
    arb_ptr  = ptr_q;
    arb_mask = 4'b0000;
`ifdef ARB_BACK2BACK_EN
    if (state_q == BUSY) begin
      arb_ptr  = own_q + 2'd1;
      arb_mask = onehot4(own_q);
    end
`endif
  end

  rr_prio4 u_rr_prio4 (
    .Req  (Req),
    .Ptr  (arb_ptr),
    .mask (arb_mask),
    .Any  (arb_any),
    .Win  (arb_win)
  );

  always_comb begin
    case (sel_of(arb_win))
      3'b000:  word_sel = A;
      3'b001:  word_sel = B;
      3'b010:  word_sel = C;
      3'b011:  word_sel = D;
      default: word_sel = '0;
    endcase
  end

  assign accept = valid_q && Ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    saida_d = saida_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ack_d   = 4'b0000;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          own_d   = arb_win;
          saida_d = word_sel;
          sel_d   = sel_of(arb_win);
          ack_d   = onehot4(arb_win);
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        // Output stays frozen until the consumer takes it; Req is not looked at here
        // unless back-to-back re-arbitration is enabled.
        if (accept) begin
          ptr_d = own_q + 2'd1;
`ifdef ARB_BACK2BACK_EN
          if (arb_any) begin
            own_d   = arb_win;
            saida_d = word_sel;
            sel_d   = sel_of(arb_win);
            ack_d   = onehot4(arb_win);
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            sel_d   = SEL_NONE;
          end
`else
          state_d = IDLE;
          valid_d = 1'b0;
          sel_d   = SEL_NONE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      saida_q <= '0;
      sel_q   <= SEL_NONE;
      valid_q <= 1'b0;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      saida_q <= saida_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign Ack     = ack_q;
  assign Seletor = sel_q;
  assign Saida   = saida_q;
  assign Valid   = valid_q;

endmodule
